// File: rtl/rv32im_pkg.sv
// Shared RV32IM definitions: ALU control codes, multiply/divide FSM states
// and small decode helpers used by the execute stage.
package rv32im_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [4:0] ALU_MUL    = 5'b10010;
    localparam logic [4:0] ALU_MULH   = 5'b10011;
    localparam logic [4:0] ALU_MULHSU = 5'b10100;
    localparam logic [4:0] ALU_MULHU  = 5'b10101;
    localparam logic [4:0] ALU_DIV    = 5'b10110;
    localparam logic [4:0] ALU_DIVU   = 5'b10111;
    localparam logic [4:0] ALU_REM    = 5'b11000;
    localparam logic [4:0] ALU_REMU   = 5'b11001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    function automatic logic is_muldiv_op(input logic [4:0] code);
        return (code >= ALU_MUL) && (code <= ALU_REMU);
    endfunction

    // Only meaningful for codes already known to be M-extension codes.
    function automatic logic is_mul_op(input logic [4:0] code);
        return code <= ALU_MULHU;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage request/response bundle between the core and the
// multiply/divide unit.
interface muldiv_unit_if;
    import rv32im_pkg::*;

    // start is a request that is accepted only while busy is low; operands and
    // alu_ctrl need only be valid in that cycle. done pulses for one cycle and
    // result stays valid until the next accepted start.
    logic            start;
    logic [4:0]      alu_ctrl;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, alu_ctrl, src_a, src_b,
        input  busy, done, result
    );

    modport slave (
        input  start, alu_ctrl, src_a, src_b,
        output busy, done, result
    );

endinterface

// File: rtl/abs_val.sv
// Operand magnitude extraction: two's-complement magnitude and sign bit,
// with the sign ignored when the operand is treated as unsigned.
module abs_val
    import rv32im_pkg::*;
(
    input  logic [XLEN-1:0] value,
    input  logic            is_signed,
    output logic [XLEN-1:0] mag,
    output logic            neg
);

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    assign neg = is_signed & value[XLEN-1];
    assign mag = neg ? ((~value) + XLEN'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32IM multiply/divide unit: one bit per cycle on unsigned
// magnitudes, sign fix-up at the end, one-cycle done pulse.
module muldiv_unit
    import rv32im_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    muldiv_unit_if.slave      bus,
    output md_state_t         dbg_state
);

    md_state_t state, next_state;

    logic [4:0]        op_q;
    logic              sign_diff_q;
    logic              a_neg_q;
    logic [CNT_W-1:0]  count_q;
    logic [XLEN-1:0]   operand_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   result_q;

    logic            accept;
    logic            a_signed, b_signed;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            a_neg, b_neg;
    logic            div_by_zero, sgn_ovf, special;
    logic [XLEN-1:0] special_result;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;

    assign accept = bus.start && is_muldiv_op(bus.alu_ctrl);

    always_comb begin
        a_signed = (bus.alu_ctrl == ALU_MULH) || (bus.alu_ctrl == ALU_MULHSU) ||
                   (bus.alu_ctrl == ALU_DIV)  || (bus.alu_ctrl == ALU_REM);
        b_signed = (bus.alu_ctrl == ALU_MULH) || (bus.alu_ctrl == ALU_DIV) ||
                   (bus.alu_ctrl == ALU_REM);
    end

    abs_val u_abs_a (.value(bus.src_a), .is_signed(a_signed), .mag(a_mag), .neg(a_neg));
    abs_val u_abs_b (.value(bus.src_b), .is_signed(b_signed), .mag(b_mag), .neg(b_neg));

    // Divide corner cases are resolved at issue and bypass the iteration.
    always_comb begin
        div_by_zero = !is_mul_op(bus.alu_ctrl) && (bus.src_b == '0);
        sgn_ovf     = ((bus.alu_ctrl == ALU_DIV) || (bus.alu_ctrl == ALU_REM)) &&
                      (bus.src_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.src_b == '1);
        special     = div_by_zero || sgn_ovf;
        special_result = '0;
        if (div_by_zero) begin
            if ((bus.alu_ctrl == ALU_DIV) || (bus.alu_ctrl == ALU_DIVU))
                special_result = '1;
            else
                special_result = bus.src_a;
        end else if (bus.alu_ctrl == ALU_DIV) begin
            special_result = {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                    (prod_q[0] ? {1'b0, operand_q} : '0);
        div_shift = {rem_q, prod_q[XLEN-1]};
        div_trial = div_shift - {1'b0, operand_q};
    end

    always_comb begin
        prod_fix = sign_diff_q ? ((~prod_q) + (2*XLEN)'(1)) : prod_q;
        quot_fix = sign_diff_q ? ((~prod_q[XLEN-1:0]) + XLEN'(1)) : prod_q[XLEN-1:0];
        rem_fix  = a_neg_q ? ((~rem_q) + XLEN'(1)) : rem_q;
        case (op_q)
            ALU_MUL:                        fix_result = prod_fix[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:              fix_result = quot_fix;
            default:                        fix_result = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        bus.busy   = 1'b1;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (accept) next_state = special ? DONE : CALC;
            end
            CALC: if (count_q == '0) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: begin
                bus.done   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // For divides prod_q[XLEN-1:0] holds the dividend shifting out and the
    // quotient shifting in; operand_q holds the multiplicand or divisor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q        <= '0;
            sign_diff_q <= 1'b0;
            a_neg_q     <= 1'b0;
            count_q     <= '0;
            operand_q   <= '0;
            prod_q      <= '0;
            rem_q       <= '0;
            result_q    <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q        <= bus.alu_ctrl;
                    sign_diff_q <= a_neg ^ b_neg;
                    a_neg_q     <= a_neg;
                    count_q     <= CNT_W'(XLEN-1);
                    rem_q       <= '0;
                    if (is_mul_op(bus.alu_ctrl)) begin
                        operand_q <= a_mag;
                        prod_q    <= {{XLEN{1'b0}}, b_mag};
                    end else begin
                        operand_q <= b_mag;
                        prod_q    <= {{XLEN{1'b0}}, a_mag};
                    end
                    if (special) result_q <= special_result;
                end
                CALC: begin
                    count_q <= count_q - CNT_W'(1);
                    if (is_mul_op(op_q)) begin
                        prod_q <= {mul_sum, prod_q[XLEN-1:1]};
                    end else begin
                        rem_q              <= div_trial[XLEN] ? div_shift[XLEN-1:0]
                                                              : div_trial[XLEN-1:0];
                        prod_q[XLEN-1:0]   <= {prod_q[XLEN-2:0], ~div_trial[XLEN]};
                    end
                end
                FIX:     result_q <= fix_result;
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, handshake/reset
// sequences and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;
    import rv32im_pkg::*;

    logic      clk;
    logic      reset;
    md_state_t dbg_state;

    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [4:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: the RISC-V M-extension rules in plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [4:0] c, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        logic signed [31:0] sa, sb, sq;
        sa = a;
        sb = b;
        sq = '0;
        case (c)
            ALU_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            ALU_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            ALU_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
            ALU_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sq = sa / sb;
                return sq;
            end
            ALU_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sq = sa % sb;
                return sq;
            end
            ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] c, input logic [31:0] a,
                                       input logic [31:0] b);
        logic is_div;
        is_div = (c >= ALU_DIV);
        if (is_div && b == 0) return 0;
        if ((c == ALU_DIV || c == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 0;
        return 33;
    endfunction

    // Issue one op; lat = posedges after the start edge until done is seen.
    // disturb >= 0 raises start (different op) at that negedge of the run.
    task automatic run_op(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                          input int disturb, output logic [31:0] res, output int lat,
                          output logic busy_ok);
        res = '0;
        lat = -1;
        busy_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.alu_ctrl = ctrl;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.alu_ctrl = 5'($urandom);
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (disturb == i) begin
                bus.start = 1'b1;
                bus.alu_ctrl = ALU_DIVU;
                bus.src_a = $urandom;
                bus.src_b = $urandom | 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                lat = i;
                res = bus.result;
                break;
            end
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("done_one_cycle", {63'd0, bus.done}, 64'd0);
        check("busy_after_done", {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic do_vec(input string name, input logic [4:0] ctrl, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int disturb);
        logic [31:0] res;
        int lat;
        logic busy_ok;
        exp_q.push_back(exp);
        run_op(ctrl, a, b, disturb, res, lat, busy_ok);
        check({name, "_result"}, {32'd0, res}, {32'd0, exp_q.pop_front()});
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_busy"}, {63'd0, busy_ok}, 64'd1);
    endtask

    task automatic idle_check(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({name, "_busy"}, {63'd0, bus.busy}, 64'd0);
            check({name, "_done"}, {63'd0, bus.done}, 64'd0);
        end
    endtask

    initial begin
        logic [4:0]  bad_codes[3];
        logic [4:0]  c;
        logic [31:0] a, b;

        vecs[0]  = '{ALU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{ALU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{ALU_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[4]  = '{ALU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{ALU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{ALU_DIVU,   32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 33};
        vecs[7]  = '{ALU_REMU,   32'hFFFF_FFF9,  32'd2,         32'd1,         33};
        vecs[8]  = '{ALU_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 0};
        vecs[9]  = '{ALU_REM,    32'd5,          32'd0,         32'd5,         0};
        vecs[10] = '{ALU_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 0};
        vecs[11] = '{ALU_REMU,   32'd5,          32'd0,         32'd5,         0};
        vecs[12] = '{ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0};
        vecs[13] = '{ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.alu_ctrl = '0;
        bus.src_a = '0;
        bus.src_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);
        check("reset_result", {32'd0, bus.result}, 64'd0);
        check("reset_state", {62'd0, dbg_state}, {62'd0, IDLE});
        reset = 1'b0;

        foreach (vecs[i])
            do_vec($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].lat, -1);

        // start during CALC and in the done cycle must both be ignored
        do_vec("start_in_calc", ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 5);
        do_vec("start_in_done", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, 33);
        idle_check("after_done_start", 3);
        do_vec("special_start_in_done", ALU_REM, 32'd9, 32'd0, 32'd9, 0, 0);
        idle_check("after_special_done_start", 2);

        bad_codes[0] = 5'b00000;
        bad_codes[1] = 5'b10001;
        bad_codes[2] = 5'b11010;
        foreach (bad_codes[i]) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.alu_ctrl = bad_codes[i];
            bus.src_a = $urandom;
            bus.src_b = $urandom;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            idle_check($sformatf("bad_code%0d", i), 3);
        end

        // abort a divu mid-iteration
        @(negedge clk);
        bus.start = 1'b1;
        bus.alu_ctrl = ALU_DIVU;
        bus.src_a = 32'hDEAD_BEEF;
        bus.src_b = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_done", {63'd0, bus.done}, 64'd0);
        check("abort_result", {32'd0, bus.result}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_check("abort_no_done", 40);
        do_vec("after_abort_mul", ALU_MUL, 32'd3, 32'd4, 32'h0000_000C, 33, -1);

        for (int n = 0; n < 150; n++) begin
            c = ALU_MUL + 5'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = $urandom_range(1, 15);
                3:       b = -$urandom_range(1, 15);
                default: b = $urandom;
            endcase
            do_vec($sformatf("rand%0d", n), c, a, b, ref_result(c, a, b),
                   ref_latency(c, a, b), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide execution unit for the RV32IM core: the consumer of the ALU decoder's M-extension control codes (alu_ctrl 10010–11001). It sits beside the single-cycle ALU in the execute stage. It accepts one operation per start pulse, computes one bit per cycle, and returns a 32-bit result with a one-cycle done pulse. The core stalls on busy.

## Interface
- XLEN, 32, operand/result width; iteration count equals XLEN.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; aborts any operation.
- start  input  1  request; sampled only in IDLE.
- alu_ctrl  input  5  operation code: 10010 mul, 10011 mulh, 10100 mulhsu, 10101 mulhu, 10110 div, 10111 divu, 11000 rem, 11001 remu.
- src_a  input  XLEN  rs1 operand (multiplicand/dividend).
- src_b  input  XLEN  rs2 operand (multiplier/divisor).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  final value; held from done until next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE. Reset forces IDLE, busy=0, done=0, result=0, all internal registers 0.
- IDLE: start=1 with a valid M code → latch op, operand magnitudes and sign flags, count=XLEN-1 → CALC. Start with any other code is ignored: stay IDLE, no done.
- Signedness:
  - mulh/div/rem: both operands signed.
  - mulhsu: src_a signed, src_b unsigned.
  - mul/mulhu/divu/remu: both unsigned (mul low word is sign-agnostic).
- Special cases detected in IDLE skip CALC/FIX and go straight to DONE with the result loaded:
  - divisor 0: div/divu → all ones; rem/remu → src_a.
  - signed overflow (div/rem, src_a=0x80000000, src_b=0xFFFFFFFF): div → 0x80000000, rem → 0.
- CALC, multiply: shift-add on a 2×XLEN product register, one multiplier bit per cycle.
- CALC, divide: restoring division; per cycle shift remainder:quotient left by 1, trial-subtract divisor, set quotient bit if non-negative.
- CALC: count decrements; at count=0 → FIX.
- FIX: negate the product if operand signs differ. Negate the quotient if dividend sign ≠ divisor sign. Negate the remainder if the dividend is negative. Select the result word:
  - mul: low XLEN bits.
  - mulh*: high XLEN bits.
  - div*: quotient.
  - rem*: remainder.
  - Then → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- Arithmetic: magnitude negation is two's complement in XLEN bits. 0x80000000 magnitude is 0x80000000 unsigned (no overflow in the datapath). Product width 2×XLEN, remainder XLEN+1 for the trial subtract.

## Timing
- Normal path: start sampled at edge N. CALC occupies edges N+1..N+XLEN. FIX → DONE at edge N+XLEN+1. done high in cycle N+XLEN+1..N+XLEN+2. busy low again after edge N+XLEN+2.
- Total latency 34 cycles at XLEN=32.
- Special-case path: done high in the cycle immediately after edge N; busy high for that one cycle.
- Handshake:
  - start while busy=1 is ignored; operands are not re-sampled.
  - start in the same cycle as done is ignored (state is DONE, not IDLE).
  - src_a/src_b/alu_ctrl need only be valid in the start cycle.
- Reset asserted mid-operation: immediate return to IDLE, busy=0, done=0, result=0; no done pulse for the aborted op.

## Structure
- Shared package rv32im_pkg holds:
  - ALU control code constants (ALU_MUL … ALU_REMU), shared with the ALU decoder.
  - the muldiv state enum (IDLE, CALC, FIX, DONE).
- Sub-module abs_val (combinational: input value + signed flag → magnitude, sign bit), instantiated once per operand.
- Counter width is $clog2(XLEN).

## Test plan
- mul 7 × 0xFFFFFFFD (-3) → result 0xFFFFFFEB; done exactly 34 cycles after start edge; busy high throughout.
- mulh 0x80000000 × 0x80000000 → 0x40000000; mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; mulhsu 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- div 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD; rem same operands → 0xFFFFFFFF; divu 0xFFFFFFF9 / 2 → 0x7FFFFFFC; remu → 1.
- div 5 / 0 → 0xFFFFFFFF, rem 5 / 0 → 5, each with done one cycle after start; div 0x80000000 / 0xFFFFFFFF → 0x80000000, rem → 0.
- start pulsed during CALC with different operands → ignored, original result returned; start with alu_ctrl=00000 in IDLE → no busy, no done.
- reset asserted at cycle 10 of a divu → busy=0, done=0, result=0 next cycle; a fresh mul 3 × 4 then completes with 0x0000000C.
